// File: rtl/qkv_sink_pkg.sv
// Shared widths, saturation helpers, element types and FSM states for the Q/K/V sink.
package qkv_pkg;

    localparam int unsigned DEF_N     = 768;
    localparam int unsigned DEF_DW    = 4;
    localparam int unsigned DEF_SHIFT = 6;

    // Accumulator width produced by the projection unit for hidden size n.
    function automatic int unsigned calc_aw(input int unsigned n, input int unsigned dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int sat_max(input int unsigned dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned dw);
        return -(1 << (dw - 1));
    endfunction

    localparam int unsigned DEF_AW      = calc_aw(DEF_N, DEF_DW);
    localparam int          DEF_SAT_MAX = sat_max(DEF_DW);
    localparam int          DEF_SAT_MIN = sat_min(DEF_DW);

    typedef logic signed [DEF_AW-1:0] wide_t;
    typedef logic signed [DEF_DW-1:0] narrow_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

endpackage

// File: rtl/qkv_sink_if.sv
// Projection-result / Q-handshake / cache-read bus between projection, sink and attention.
interface qkv_sink_if #(
    parameter int unsigned DW     = 4,
    parameter int unsigned PE_NUM = 12,
    parameter int unsigned AW     = 18,
    parameter int unsigned IW     = 6
);
    logic                           in_valid;
    logic [PE_NUM-1:0][AW-1:0]      in_q;
    logic [PE_NUM-1:0][AW-1:0]      in_k;
    logic [PE_NUM-1:0][AW-1:0]      in_v;
    logic                           q_valid;
    logic                           q_ready;
    logic [PE_NUM-1:0][DW-1:0]      q_out;
    logic                           rd_en;
    logic [IW-1:0]                  rd_idx;
    logic                           rd_valid;
    logic                           rd_err;
    logic [PE_NUM-1:0][DW-1:0]      rd_k;
    logic [PE_NUM-1:0][DW-1:0]      rd_v;

    modport master (
        output in_valid, in_q, in_k, in_v, q_ready, rd_en, rd_idx,
        input  q_valid, q_out, rd_valid, rd_err, rd_k, rd_v
    );

    modport slave (
        input  in_valid, in_q, in_k, in_v, q_ready, rd_en, rd_idx,
        output q_valid, q_out, rd_valid, rd_err, rd_k, rd_v
    );
endinterface

// File: rtl/qkv_sink_requant_sat.sv
// Requantizes one wide accumulator to DW bits: optional half-up bias, arithmetic shift, saturate.
// Rounding is enabled by defining QKV_SINK_ROUND_EN.
module requant_sat
    import qkv_pkg::*;
#(
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic [AW-1:0] x_i,
    output logic [DW-1:0] y_o
);

    localparam int unsigned EW = AW + 1;
    localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(DW));
    localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(DW));
`ifdef QKV_SINK_ROUND_EN
    // Half of one output LSB; zero when SHIFT is 0.
    localparam logic signed [EW-1:0] BIAS = EW'((1 << SHIFT) >> 1);
`else
    localparam logic signed [EW-1:0] BIAS = '0;
`endif

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;

    always_comb begin
        ext     = $signed({x_i[AW-1], x_i}) + BIAS;
        shifted = ext >>> SHIFT;
        if (shifted > MAX_V) begin
            y_o = MAX_V[DW-1:0];
        end else if (shifted < MIN_V) begin
            y_o = MIN_V[DW-1:0];
        end else begin
            y_o = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/qkv_sink.sv
// Q/K/V projection sink: requantizes heads, appends K/V to a token cache, holds Q for attention.
// Define QKV_SINK_ROUND_EN to requantize with round-half-up instead of truncation.
module qkv_sink
    import qkv_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned PE_NUM  = 12,
    parameter int unsigned SEQ_LEN = 64,
    parameter int unsigned SHIFT   = DEF_SHIFT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    qkv_sink_if.slave                      bus,
    output logic [$clog2(SEQ_LEN+1)-1:0]   tok_cnt,
    output logic                           full,
    output logic                           overflow,
    output logic                           q_overrun
);

    localparam int unsigned AW = calc_aw(N, DW);
    localparam int unsigned IW = $clog2(SEQ_LEN);
    localparam int unsigned CW = $clog2(SEQ_LEN + 1);

    typedef logic [PE_NUM-1:0][DW-1:0] vec_t;

    vec_t q_rq, k_rq, v_rq;

    for (genvar h = 0; h < PE_NUM; h++) begin : g_head
        requant_sat #(.AW(AW), .DW(DW), .SHIFT(SHIFT)) u_rq_q (.x_i(bus.in_q[h]), .y_o(q_rq[h]));
        requant_sat #(.AW(AW), .DW(DW), .SHIFT(SHIFT)) u_rq_k (.x_i(bus.in_k[h]), .y_o(k_rq[h]));
        requant_sat #(.AW(AW), .DW(DW), .SHIFT(SHIFT)) u_rq_v (.x_i(bus.in_v[h]), .y_o(v_rq[h]));
    end

    state_e        state_q, state_d;
    logic [CW-1:0] tok_q, tok_d;
    logic          q_valid_q, q_valid_d;
    vec_t          q_out_q, q_out_d;
    logic          overflow_q, overflow_d;
    logic          overrun_q, overrun_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q, rd_err_d;
    vec_t          rd_k_q, rd_k_d;
    vec_t          rd_v_q, rd_v_d;
    logic          accept_c;
    logic          rd_miss_c;

    vec_t k_mem [SEQ_LEN];
    vec_t v_mem [SEQ_LEN];

    // Next-state: read response, clear, capture/drop, Q handshake.
    always_comb begin
        state_d    = state_q;
        tok_d      = tok_q;
        q_valid_d  = q_valid_q;
        q_out_d    = q_out_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        accept_c   = 1'b0;
        rd_k_d     = '0;
        rd_v_d     = '0;

        // Reads see the pre-edge count, so a same-edge write is never forwarded.
        rd_miss_c  = CW'(bus.rd_idx) >= tok_q;
        rd_valid_d = bus.rd_en;
        rd_err_d   = bus.rd_en && rd_miss_c;
        if (bus.rd_en && !rd_miss_c) begin
            rd_k_d = k_mem[bus.rd_idx];
            rd_v_d = v_mem[bus.rd_idx];
        end

        if (clear) begin
            state_d    = ST_FILL;
            tok_d      = '0;
            q_valid_d  = 1'b0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (q_valid_q && bus.q_ready) begin
                q_valid_d = 1'b0;
            end
            if (bus.in_valid) begin
                case (state_q)
                    ST_FILL: begin
                        accept_c  = 1'b1;
                        tok_d     = tok_q + CW'(1);
                        q_out_d   = q_rq;
                        q_valid_d = 1'b1;
                        if (q_valid_q && !bus.q_ready) begin
                            overrun_d = 1'b1;
                        end
                        if (tok_q == CW'(SEQ_LEN - 1)) begin
                            state_d = ST_FULL;
                        end
                    end
                    ST_FULL: overflow_d = 1'b1;
                    default: state_d = ST_FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            tok_q      <= '0;
            q_valid_q  <= 1'b0;
            q_out_q    <= '0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_k_q     <= '0;
            rd_v_q     <= '0;
        end else begin
            state_q    <= state_d;
            tok_q      <= tok_d;
            q_valid_q  <= q_valid_d;
            q_out_q    <= q_out_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_k_q     <= rd_k_d;
            rd_v_q     <= rd_v_d;
        end
    end

    // Cache storage carries no reset; validity is tracked by tok_q alone.
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            k_mem[tok_q[IW-1:0]] <= k_rq;
            v_mem[tok_q[IW-1:0]] <= v_rq;
        end
    end

    assign bus.q_valid  = q_valid_q;
    assign bus.q_out    = q_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_k     = rd_k_q;
    assign bus.rd_v     = rd_v_q;
    assign tok_cnt      = tok_q;
    assign full         = (state_q == ST_FULL);
    assign overflow     = overflow_q;
    assign q_overrun    = overrun_q;

endmodule

// File: doc/qkv_sink.md
Name: qkv_sink

Overview:
- Receiving end of the Q/K/V projection output interface. Consumes one-cycle `in_valid` pulses carrying per-head wide accumulator results for Q, K and V.
- Requantizes each head result back to DW-bit signed by arithmetic shift and saturation.
- Appends K and V to a per-token cache; holds Q in a valid/ready output register for the attention-score stage.
- Sits between the projection unit and the attention datapath; provides a random-access read port into the K/V cache.

Parameters:
- N, 768, hidden size; sets accumulator width only.
- DW, 4, requantized element bitwidth.
- PE_NUM, 12, heads per vector.
- SEQ_LEN, 64, K/V cache depth in tokens.
- SHIFT, 6, requant right-shift amount, 0 <= SHIFT < AW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  empties cache, clears sticky flags.
- in_valid  in  1  one-cycle pulse; in_q/in_k/in_v valid.
- in_q, in_k, in_v  in  AW x PE_NUM  signed per-head accumulators, AW = 2*DW+$clog2(N).
- q_valid  out  1  requantized Q available.
- q_ready  in  1  downstream accepts Q.
- q_out  out  DW x PE_NUM  requantized Q.
- rd_en  in  1  cache read request.
- rd_idx  in  $clog2(SEQ_LEN)  token index.
- rd_valid  out  1  read response strobe.
- rd_err  out  1  with rd_valid: index not yet written.
- rd_k, rd_v  out  DW x PE_NUM  cached K/V for rd_idx.
- tok_cnt  out  $clog2(SEQ_LEN+1)  tokens stored.
- full  out  1  tok_cnt == SEQ_LEN.
- overflow  out  1  sticky: in_valid dropped while full.
- q_overrun  out  1  sticky: Q overwritten while q_valid && !q_ready.

Behaviour:
- Reset: all outputs 0; q_out, rd_k, rd_v = 0; cache contents don't-care.
- Requant per element: r = x >>> SHIFT (arithmetic). Saturate to [-2^(DW-1), 2^(DW-1)-1]. Computed on AW+1 bits; no wrap.
- Capture: in_valid sampled at edge t. Results visible from cycle t+1:
  - Q loaded into q_out; q_valid = 1.
  - K/V written to slot tok_cnt; tok_cnt += 1.
- Q handshake:
  - Transfer occurs when q_valid && q_ready. q_valid drops next cycle unless a new capture happens that same edge; in that case it stays 1 with the new Q and no overrun.
  - in_valid while q_valid && !q_ready: overwrite Q, set q_overrun.
- Full: in_valid while full drops K/V and Q entirely and sets overflow. tok_cnt holds. No wrap-around.
- clear:
  - tok_cnt = 0; overflow = 0; q_overrun = 0; q_valid = 0 next cycle.
  - clear has priority over a simultaneous in_valid, which is discarded.
- Read:
  - rd_en at edge t gives rd_valid = 1 in cycle t+1, with rd_k/rd_v = slot rd_idx.
  - rd_idx >= tok_cnt (sampled at t): rd_err = 1 and data = 0.
  - A read at the index written on the same edge returns rd_err = 1; the write is not forwarded.
  - rd_valid is a single-cycle pulse per rd_en; back-to-back reads give one response per cycle.
- FSM, 2 states:
  - FILL: accepting tokens.
  - FULL: dropping tokens.
  - FILL -> FULL when the write makes tok_cnt == SEQ_LEN.
  - FULL -> FILL on clear or rst.
- rst mid-operation: same as reset; a pending in_valid is lost.

Optional Feature:
- Macro: QKV_SINK_ROUND_EN.
- Defined: round half-up before shift, r = (x + 2^(SHIFT-1)) >>> SHIFT, then saturate. SHIFT == 0 means no bias. The add uses AW+1 bits so it cannot wrap.
- Undefined: truncating arithmetic shift only.

Decomposition:
- Package qkv_pkg:
  - AW width function/localparam.
  - DW min/max saturation constants.
  - Element typedefs for wide and narrow signed values.
  - FSM state enum (FILL, FULL).
- Sub-module requant_sat: one element, AW in, DW out, combinational, honours QKV_SINK_ROUND_EN. Instantiated 3*PE_NUM times.

Test Plan (DW=4, SHIFT=2, SEQ_LEN=4, PE_NUM=2):
- in_q = {13, 14}, in_valid pulse, q_ready = 0 -> next cycle q_valid = 1. q_out = {3, 3} without macro, {3, 4} with. tok_cnt = 1.
- in_k = {40, -40} -> rd_en with rd_idx = 0 next cycle -> rd_valid = 1, rd_k = {7, -8}, rd_err = 0. Also in_v = {-6, 0} -> rd_v = {-2, 0} truncating, {-1, 0} rounding.
- Second in_valid while q_valid = 1 and q_ready = 0 -> q_out updated, q_overrun = 1. With q_ready = 1 on the capture edge instead -> q_valid stays 1, q_overrun = 0.
- Five in_valid pulses -> after the 4th, full = 1 and tok_cnt = 4. The 5th sets overflow = 1; tok_cnt stays 4.
- rd_idx = 2 with tok_cnt = 2 -> rd_valid = 1, rd_err = 1, data 0. Then clear -> tok_cnt = 0, full = 0, overflow = 0. clear with simultaneous in_valid -> tok_cnt = 0.
- rst asserted for one cycle mid-stream -> all outputs 0 next cycle. A new token then writes slot 0.
